// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch/decode constants, IF/ID record type and fetch state encoding
package fetch_unit_pkg;

    localparam int AW = 8;
    localparam int IW = 16;
    localparam logic [AW-1:0] PC_STEP  = AW'(2);
    localparam logic [AW-1:0] RESET_PC = 8'h00;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam logic [OPC_MSB-OPC_LSB:0] HALT_OPC = 4'hE;
    localparam logic [IW-1:0] NOP_INSTR = 16'h0000;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
    } ifid_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

    function automatic logic is_halt(input logic [OPC_MSB-OPC_LSB:0] opc);
        return opc == HALT_OPC;
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// rtl/ifid_reg.sv - IF/ID pipeline register with hold and clear controls
module ifid_reg
    import fetch_unit_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  hold_i,
    input  logic  clear_i,
    input  ifid_t d_i,
    output ifid_t q_o
);

    ifid_t q_q;

    // Clear wins over hold: a squash must kill the slot even while decode is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '{valid: 1'b0, pc: '0, instr: NOP_INSTR};
        end else if (clear_i) begin
            q_q.valid <= 1'b0;
            q_q.instr <= NOP_INSTR;
        end else if (!hold_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, halt detection, fetch counter, IF/ID capture
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_addr,
    output logic [AW-1:0] pc_out,
    input  logic [IW-1:0] instr_in,
    output logic          ifid_valid,
    output logic [AW-1:0] ifid_pc,
    output logic [AW-1:0] ifid_pc_next,
    output logic [IW-1:0] ifid_instr,
    output logic          halted,
    output logic [15:0]   fetch_count
);

    fetch_state_t  state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          ifid_hold, ifid_clear;
    ifid_t         ifid_d, ifid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        ifid_hold  = 1'b0;
        ifid_clear = 1'b0;
        if (redirect) begin
            pc_d       = redirect_addr & ~AW'(1);
            state_d    = ST_RUN;
            ifid_clear = 1'b1;
        end else if (state_q == ST_HALT) begin
            ifid_hold  = stall;
            ifid_clear = !stall;
        end else if (stall) begin
            ifid_hold = 1'b1;
        end else begin
            if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
            // The halt instruction itself is captured; only the PC stops here.
            if (is_halt(instr_in[OPC_MSB:OPC_LSB])) begin
                state_d = ST_HALT;
            end else begin
                pc_d = pc_q + PC_STEP;
            end
        end
    end

    assign ifid_d = '{valid: 1'b1, pc: pc_q, instr: instr_in};

    ifid_reg u_ifid_reg (
        .clk     (clk),
        .rst     (rst),
        .hold_i  (ifid_hold),
        .clear_i (ifid_clear),
        .d_i     (ifid_d),
        .q_o     (ifid_q)
    );

    assign pc_out       = pc_q;
    assign halted       = (state_q == ST_HALT);
    assign fetch_count  = cnt_q;
    assign ifid_valid   = ifid_q.valid;
    assign ifid_pc      = ifid_q.pc;
    assign ifid_instr   = ifid_q.instr;
    assign ifid_pc_next = ifid_q.pc + PC_STEP;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with behavioural reference model
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, stall, redirect;
    logic [7:0]  redirect_addr;
    logic [7:0]  pc_out;
    logic [15:0] instr_in;
    logic        ifid_valid;
    logic [7:0]  ifid_pc, ifid_pc_next;
    logic [15:0] ifid_instr;
    logic        halted;
    logic [15:0] fetch_count;

    logic [15:0] im [0:127];

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    assign instr_in = im[pc_out[7:1]];

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .pc_out        (pc_out),
        .instr_in      (instr_in),
        .ifid_valid    (ifid_valid),
        .ifid_pc       (ifid_pc),
        .ifid_pc_next  (ifid_pc_next),
        .ifid_instr    (ifid_instr),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    logic [7:0]  m_pc, m_ipc;
    logic [15:0] m_instr, m_cnt;
    logic        m_valid, m_halted, m_zero;

    always @(posedge clk) begin : model
        logic [15:0] f;
        if (rst) begin
            m_pc = 8'h00; m_valid = 1'b0; m_ipc = 8'h00; m_instr = 16'h0000;
            m_halted = 1'b0; m_cnt = 16'h0000; m_zero = 1'b1;
        end else if (redirect) begin
            m_pc = {redirect_addr[7:1], 1'b0};
            m_valid = 1'b0; m_instr = 16'h0000; m_zero = 1'b1; m_halted = 1'b0;
        end else if (m_halted) begin
            if (!stall) m_valid = 1'b0;
        end else if (!stall) begin
            f = im[m_pc / 2];
            m_ipc = m_pc; m_instr = f; m_valid = 1'b1; m_zero = 1'b0;
            if (m_cnt < 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (f[15:12] == 4'hE) m_halted = 1'b1;
            else m_pc = 8'((m_pc + 2) % 256);
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("pc_out", 32'(pc_out), 32'(m_pc));
            cmp("ifid_valid", 32'(ifid_valid), 32'(m_valid));
            cmp("halted", 32'(halted), 32'(m_halted));
            cmp("fetch_count", 32'(fetch_count), 32'(m_cnt));
            if (m_valid) begin
                cmp("ifid_pc", 32'(ifid_pc), 32'(m_ipc));
                cmp("ifid_instr", 32'(ifid_instr), 32'(m_instr));
                cmp("ifid_pc_next", 32'(ifid_pc_next), 32'(8'((m_ipc + 2) % 256)));
            end else if (m_zero) begin
                cmp("ifid_instr_squashed", 32'(ifid_instr), 32'h0);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) im[i] = {4'($urandom_range(0, 13)), 12'($urandom)};
        im[8'h04 / 2] = 16'h93FF;
        im[8'h08 / 2] = 16'hF564;
        im[8'h0A / 2] = 16'hF155;
        im[8'h30 / 2] = 16'hFCC0;
        im[8'h36 / 2] = 16'hEFFF;
        im[8'h50 / 2] = 16'hE123;

        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_addr = 8'h00;
        tick(2);
        chk_en = 1'b1;
        cmp("rst_pc", 32'(pc_out), 32'h00);
        cmp("rst_valid", 32'(ifid_valid), 32'h0);
        cmp("rst_instr", 32'(ifid_instr), 32'h0000);
        cmp("rst_count", 32'(fetch_count), 32'h0);
        cmp("rst_halted", 32'(halted), 32'h0);
        rst = 1'b0;

        tick(3);
        cmp("seq_ifid_pc", 32'(ifid_pc), 32'h04);
        cmp("seq_ifid_instr", 32'(ifid_instr), 32'h93FF);
        cmp("seq_pc_next", 32'(ifid_pc_next), 32'h06);
        cmp("seq_count", 32'(fetch_count), 32'd3);

        tick(2);
        stall = 1'b1;
        tick(3);
        cmp("stall_pc", 32'(pc_out), 32'h0A);
        cmp("stall_ifid_pc", 32'(ifid_pc), 32'h08);
        cmp("stall_ifid_instr", 32'(ifid_instr), 32'hF564);
        cmp("stall_count", 32'(fetch_count), 32'd5);
        stall = 1'b0;
        tick(1);
        cmp("unstall_ifid_pc", 32'(ifid_pc), 32'h0A);
        cmp("unstall_ifid_instr", 32'(ifid_instr), 32'hF155);

        tick(11);
        cmp("pre_redirect_pc", 32'(pc_out), 32'h22);
        stall = 1'b1; redirect = 1'b1; redirect_addr = 8'h31;
        tick(1);
        cmp("redirect_pc", 32'(pc_out), 32'h30);
        cmp("redirect_valid", 32'(ifid_valid), 32'h0);
        cmp("redirect_count", 32'(fetch_count), 32'd17);
        stall = 1'b0; redirect = 1'b0;
        tick(1);
        cmp("post_redirect_ifid_pc", 32'(ifid_pc), 32'h30);
        cmp("post_redirect_instr", 32'(ifid_instr), 32'hFCC0);

        tick(3);
        cmp("halt_ifid_pc", 32'(ifid_pc), 32'h36);
        cmp("halt_ifid_instr", 32'(ifid_instr), 32'hEFFF);
        cmp("halt_valid", 32'(ifid_valid), 32'h1);
        cmp("halt_flag", 32'(halted), 32'h1);
        cmp("halt_pc", 32'(pc_out), 32'h36);
        tick(2);
        cmp("halted_bubble", 32'(ifid_valid), 32'h0);
        cmp("halted_count", 32'(fetch_count), 32'd21);
        redirect = 1'b1; redirect_addr = 8'h00;
        tick(1);
        cmp("unhalt_flag", 32'(halted), 32'h0);
        cmp("unhalt_pc", 32'(pc_out), 32'h00);
        redirect = 1'b0;
        tick(1);
        cmp("resume_pc", 32'(pc_out), 32'h02);

        redirect = 1'b1; redirect_addr = 8'hFE;
        tick(1);
        redirect = 1'b0;
        tick(1);
        cmp("wrap_pc", 32'(pc_out), 32'h00);
        cmp("wrap_pc_next", 32'(ifid_pc_next), 32'h00);

        redirect = 1'b1; redirect_addr = 8'h1A;
        tick(1);
        redirect = 1'b0;
        tick(1);
        cmp("pre_rst_pc", 32'(pc_out), 32'h1C);
        rst = 1'b1;
        tick(1);
        cmp("midrst_pc", 32'(pc_out), 32'h00);
        cmp("midrst_valid", 32'(ifid_valid), 32'h0);
        cmp("midrst_instr", 32'(ifid_instr), 32'h0000);
        cmp("midrst_count", 32'(fetch_count), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 299) == 0);
            redirect      = ($urandom_range(0, 15) == 0);
            redirect_addr = 8'($urandom);
            stall         = ($urandom_range(0, 3) == 0);
            tick(1);
        end

        rst = 1'b0; stall = 1'b0;
        im[8'h36 / 2] = 16'h93FF;
        im[8'h50 / 2] = 16'h1234;
        redirect = 1'b1; redirect_addr = 8'h00;
        tick(1);
        redirect = 1'b0;
        tick(65536);
        cmp("sat_count", 32'(fetch_count), 32'hFFFF);
        tick(2);
        cmp("sat_count_hold", 32'(fetch_count), 32'hFFFF);
        cmp("sat_valid", 32'(ifid_valid), 32'h1);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the instruction memory (IM).
- Holds the program counter and drives the IM address.
- Captures the IM's combinational instruction into the IF/ID pipeline register.
- Handles stall, branch/jump redirect (with squash), address wrap, and halt-on-fetch of the halt opcode.

Parameters:
AW, 8, instruction address width (byte address)
IW, 16, instruction width
PC_STEP, 2, PC increment per sequential fetch (16-bit instructions, byte-addressed)
RESET_PC, 8'h00, PC value after reset
HALT_OPC, 4'hE, opcode (instr[15:12]) that halts fetch

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  decode-side hazard; freeze PC and IF/ID
redirect  input  1  branch/jump resolved taken; load redirect_addr, squash IF/ID
redirect_addr  input  AW  redirect target; bit 0 ignored (forced 0)
pc_out  output  AW  current PC, wired to IM address input
instr_in  input  IW  IM instruction for pc_out, valid in the same cycle (combinational IM)
ifid_valid  output  1  IF/ID holds a real instruction
ifid_pc  output  AW  PC of the instruction in IF/ID
ifid_pc_next  output  AW  ifid_pc + PC_STEP, wraps modulo 2^AW
ifid_instr  output  IW  instruction in IF/ID
halted  output  1  halt opcode fetched; PC frozen
fetch_count  output  16  number of instructions accepted into IF/ID; saturates at 16'hFFFF

Behaviour:
- All state updates occur on the rising edge of clk. Outputs are registered, except ifid_pc_next (combinational from ifid_pc).
- Reset (rst=1), highest priority:
  - pc=RESET_PC
  - ifid_valid=0, ifid_pc=0, ifid_instr=16'h0000
  - halted=0, fetch_count=0
  - rst asserted mid-operation discards everything at the next edge.
- Per-edge priority: rst > redirect > halted > stall > advance.
- Redirect (redirect=1):
  - pc <= {redirect_addr[AW-1:1],1'b0}.
  - ifid_valid <= 0; ifid_instr <= 16'h0000.
  - halted <= 0: a speculatively fetched halt is squashed.
  - fetch_count unchanged.
  - redirect overrides stall in the same cycle.
- Halted (halted=1, no redirect):
  - pc frozen.
  - If stall=0: ifid_valid <= 0 (bubble).
  - If stall=1: IF/ID holds.
  - halted stays set until rst or redirect.
- Stall (stall=1, no redirect, not halted): pc, IF/ID and fetch_count all hold.
- Advance (none of the above):
  - ifid_pc <= pc; ifid_instr <= instr_in; ifid_valid <= 1.
  - fetch_count <= fetch_count+1, saturating.
  - If instr_in[15:12]==HALT_OPC: halted <= 1 and pc holds. The halt instruction itself still enters IF/ID.
  - Otherwise pc <= pc+PC_STEP.
- Wrap-around: pc+PC_STEP is computed modulo 2^AW, so 8'hFE advances to 8'h00. ifid_pc_next wraps the same way.
- Latency: an instruction at address A appears in IF/ID one edge after pc_out==A with stall=0. Sequential throughput is one instruction per cycle.
- Instruction 16'h0000 is passed through as an ordinary instruction; it is not treated as a bubble. Only ifid_valid marks bubbles.

Decomposition:
- Shared package:
  - AW, IW, PC_STEP, RESET_PC.
  - Opcode field slice constants: OPC_MSB=15, OPC_LSB=12.
  - HALT_OPC, NOP_INSTR=16'h0000.
  - Typedef ifid_t {valid, pc, instr}, shared with the decode stage.
- One sub-module, ifid_reg: the IF/ID register with hold (stall) and clear (squash/bubble) controls.
- PC logic, halt detection and the counter live in fetch_unit.

Test Plan:
- Reset, then run with the IM program loaded and no stall/redirect:
  - pc_out steps 00,02,04,...
  - At the edge after pc_out=8'h04: ifid_instr=16'h93FF, ifid_pc=8'h04, ifid_pc_next=8'h06.
  - fetch_count increments by 1 per cycle.
- Hold stall=1 for 3 cycles while pc_out=8'h0A:
  - pc_out stays 8'h0A; IF/ID keeps 8'h08/16'hF564; fetch_count is unchanged.
  - After release, IF/ID=8'h0A/16'hF155.
- Redirect: assert redirect with redirect_addr=8'h31 while stall=1 and pc_out=8'h22:
  - Next cycle pc_out=8'h30 (bit 0 dropped) and ifid_valid=0.
  - Following edge: IF/ID=8'h30/16'hFCC0.
- Halt: fetch at pc_out=8'h36 (16'hEFFF):
  - IF/ID=8'h36/16'hEFFF with valid=1; halted=1; pc_out stays 8'h36.
  - Subsequent cycles: ifid_valid=0 and fetch_count frozen.
  - Then assert redirect to 8'h00: halted=0, fetch resumes at 8'h00.
- Wrap: redirect to 8'hFE, advance one cycle -> pc_out=8'h00 and ifid_pc_next=8'h00.
- Assert rst mid-stream at pc_out=8'h1C with IF/ID valid and halted=0:
  - Next edge: pc_out=8'h00, ifid_valid=0, ifid_instr=0, fetch_count=0.
